// File: rtl/ibex_instr_aligner.sv
// ibex_instr_aligner
// Realigns a stream of word-aligned 32-bit fetch words into instructions.
// The instructions may be 16-bit (compressed) or 32-bit and start on any
// halfword boundary. Fetch words are buffered in a small circular FIFO. A
// halfword PC selects the head halfword. A 32-bit instruction that starts in
// the upper half of the head word takes its upper half from the next entry.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   redirect_i               flush buffer and reload PC from redirect_addr_i
//   redirect_addr_i[31:0]    new PC (bit 0 ignored)
//   in_valid_i / in_ready_o  fetch word handshake
//   in_rdata_i[31:0]         fetch word
//   in_err_i                 bus error attached to the fetch word
//   out_valid_o / out_ready_i instruction handshake towards the decoder
//   out_rdata_o[31:0]        instruction; upper half zero when compressed
//   out_addr_o[31:0]         PC of out_rdata_o
//   out_err_o                a contributing fetch word carried an error
module ibex_instr_aligner #(
    parameter int unsigned DEPTH     = 3,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0] data_q [DEPTH];
    logic        err_q  [DEPTH];

    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    cnt_t        count_q, count_d;
    logic [31:0] pc_q, pc_d;

    ptr_t        head_nxt;
    logic [31:0] head_data, next_data;
    logic        head_err, next_err;
    logic [15:0] half_lo;
    logic        is_compressed, straddle;
    logic        has_one, has_two;
    logic        push, pop_instr, pop_word;

    // ---------------------------------------------------------------
    // Instruction extraction, from registered state only
    // ---------------------------------------------------------------
    assign head_nxt  = ptr_inc(head_q);
    assign head_data = data_q[head_q];
    assign head_err  = err_q[head_q];
    assign next_data = data_q[head_nxt];
    assign next_err  = err_q[head_nxt];

    assign has_one = (count_q != '0);
    assign has_two = (count_q >= cnt_t'(2));

    assign half_lo       = pc_q[1] ? head_data[31:16] : head_data[15:0];
    assign is_compressed = (half_lo[1:0] != 2'b11);
    // A 32-bit instruction that starts in the upper half takes its upper
    // half from the next FIFO entry.
    assign straddle      = pc_q[1] & ~is_compressed;

    always_comb begin
        if (is_compressed) begin
            out_rdata_o = {16'h0000, half_lo};
        end else if (straddle) begin
            out_rdata_o = {next_data[15:0], half_lo};
        end else begin
            out_rdata_o = head_data;
        end
    end

    // A faulted head word is presented at once, so the error reaches the core
    // even when the word that would complete it never arrives.
    assign out_valid_o = ~redirect_i & has_one & (~straddle | has_two | head_err);
    assign out_err_o   = has_one & (head_err | (straddle & has_two & next_err));
    assign out_addr_o  = {pc_q[31:1], 1'b0};

    assign in_ready_o = (count_q < cnt_t'(DEPTH));

    // ---------------------------------------------------------------
    // Handshakes and next state
    // ---------------------------------------------------------------
    assign push      = in_valid_i & in_ready_o;
    assign pop_instr = out_valid_o & out_ready_i;
    // The head word retires once the PC leaves it. That happens for any
    // instruction starting in the upper half, and for a 32-bit instruction
    // starting in the lower half.
    assign pop_word  = pop_instr & (pc_q[1] | ~is_compressed);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        if (redirect_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = {redirect_addr_i[31:1], 1'b0};
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop_word) begin
                head_d = head_nxt;
            end
            if (pop_instr) begin
                pc_d = pc_q + (is_compressed ? 32'd2 : 32'd4);
            end
            case ({push, pop_word})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= BOOT_ADDR;
        end else begin
            // NOTE: non-blocking assignments keep every register update in
            // this block order-independent within the clock edge.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
        end
    end

    // NOTE: the storage array has no reset; count_q == 0 already marks every
    // entry as invalid, so resetting the data would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push && !redirect_i) begin
            data_q[tail_q] <= in_rdata_i;
            err_q[tail_q]  <= in_err_i;
        end
    end

endmodule

// File: tb/tb_ibex_instr_aligner.sv
module tb_ibex_instr_aligner;

    localparam int unsigned DEPTH     = 3;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        in_valid_i;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;

    ibex_instr_aligner #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT_ADDR)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .in_valid_i      (in_valid_i),
        .in_rdata_i      (in_rdata_i),
        .in_err_i        (in_err_i),
        .in_ready_o      (in_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_rdata_o     (out_rdata_o),
        .out_addr_o      (out_addr_o),
        .out_err_o       (out_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the buffer is a queue of {err, word}. The PC addresses
    // a halfword stream that starts at word 0 of the queue.
    logic [32:0] q[$];
    logic [31:0] m_pc;

    task automatic model_out(output bit v, output logic [31:0] rd, output bit e,
                             output bit rd_known, output int len);
        logic [31:0] w0;
        logic [15:0] hw0;
        v = 0; rd = '0; e = 0; rd_known = 0; len = 2;
        if (q.size() != 0) begin
            w0  = q[0][31:0];
            hw0 = m_pc[1] ? w0[31:16] : w0[15:0];
            e   = q[0][32];
            if (hw0[1:0] != 2'b11) begin
                v = 1; rd = {16'h0, hw0}; rd_known = 1; len = 2;
            end else begin
                len = 4;
                if (!m_pc[1]) begin
                    v = 1; rd = w0; rd_known = 1;
                end else if (q.size() >= 2) begin
                    v = 1; rd = {q[1][15:0], hw0}; rd_known = 1;
                    e = e | q[1][32];
                end else begin
                    v = e;
                end
            end
        end
    endtask

    task automatic drive_idle();
        redirect_i = 0; redirect_addr_i = '0; in_valid_i = 0;
        in_rdata_i = '0; in_err_i = 0; out_ready_i = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit rd, input logic [31:0] ra, input bit iv,
                        input logic [31:0] id, input bit ie, input bit ordy);
        bit          v, e, known;
        logic [31:0] erd, npc;
        int          len, sz;
        @(negedge clk_i);
        redirect_i = rd; redirect_addr_i = ra; in_valid_i = iv;
        in_rdata_i = id; in_err_i = ie; out_ready_i = ordy;
        #1;
        model_out(v, erd, e, known, len);
        if (rd) v = 0;
        sz = q.size();
        check("in_ready", 32'(in_ready_o), 32'(sz < DEPTH));
        check("out_valid", 32'(out_valid_o), 32'(v));
        check("out_addr", out_addr_o, m_pc);
        if (v) begin
            check("out_err", 32'(out_err_o), 32'(e));
            if (known) check("out_rdata", out_rdata_o, erd);
        end
        if (rd) begin
            q.delete();
            m_pc = {ra[31:1], 1'b0};
        end else begin
            if (v && ordy) begin
                npc = m_pc + 32'(len);
                if ((m_pc >> 2) != (npc >> 2)) void'(q.pop_front());
                m_pc = npc;
            end
            if (iv && sz < DEPTH) q.push_back({ie, id});
        end
        @(posedge clk_i);
        #1;
        drive_idle();
    endtask

    task automatic peek_at_negedge();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        drive_idle();
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        q.delete();
        m_pc = BOOT_ADDR;
        #3;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_err", 32'(out_err_o), 32'd0);
        check("rst_out_addr", out_addr_o, BOOT_ADDR);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Aligned 32-bit instruction from boot
        step(0, 0, 1, 32'h0041_0113, 0, 0);
        peek_at_negedge();
        check("d34_valid", 32'(out_valid_o), 32'd1);
        check("d34_rdata", out_rdata_o, 32'h0041_0113);
        check("d34_addr", out_addr_o, 32'h80);
        step(0, 0, 0, 0, 0, 1);
        peek_at_negedge();
        check("d34_addr_after", out_addr_o, 32'h84);
        check("d34_empty", 32'(out_valid_o), 32'd0);

        // Two compressed instructions in one word
        step(1, 32'h80, 0, 0, 0, 0);
        step(0, 0, 1, 32'h4505_4501, 0, 0);
        peek_at_negedge();
        check("d35_rdata0", out_rdata_o, 32'h0000_4501);
        check("d35_addr0", out_addr_o, 32'h80);
        step(0, 0, 0, 0, 0, 1);
        peek_at_negedge();
        check("d35_rdata1", out_rdata_o, 32'h0000_4505);
        check("d35_addr1", out_addr_o, 32'h82);
        step(0, 0, 0, 0, 0, 1);
        peek_at_negedge();
        check("d35_popped", 32'(out_valid_o), 32'd0);

        // Redirect to an odd halfword, instruction straddles two words
        step(1, 32'h102, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0113_0001, 0, 1);
        peek_at_negedge();
        check("d36_wait", 32'(out_valid_o), 32'd0);
        step(0, 0, 1, 32'h0000_0041, 0, 0);
        peek_at_negedge();
        check("d36_rdata", out_rdata_o, 32'h0041_0113);
        check("d36_addr", out_addr_o, 32'h102);
        step(0, 0, 0, 0, 0, 1);
        peek_at_negedge();
        check("d36_next_addr", out_addr_o, 32'h106);

        // Fill, then pop with a simultaneous push that must be rejected
        step(1, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0000_0013 | (i << 20), 0, 0);
        peek_at_negedge();
        check("d37_full", 32'(in_ready_o), 32'd0);
        step(0, 0, 1, 32'h0AAA_0013, 0, 1);
        peek_at_negedge();
        check("d37_ready_again", 32'(in_ready_o), 32'd1);
        check("d37_addr", out_addr_o, 32'h4);

        // Error on the second word of a straddling instruction
        step(1, 32'h202, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0113_0000, 0, 0);
        step(0, 0, 1, 32'h0000_0041, 1, 0);
        peek_at_negedge();
        check("d38_err", 32'(out_err_o), 32'd1);
        check("d38_addr", out_addr_o, 32'h202);

        // PC wrap at the top of the address space
        step(1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        step(0, 0, 1, 32'h4501_0000, 0, 0);
        peek_at_negedge();
        check("d39_addr", out_addr_o, 32'hFFFF_FFFE);
        check("d39_rdata", out_rdata_o, 32'h0000_4501);
        step(0, 0, 0, 0, 0, 1);
        peek_at_negedge();
        check("d39_wrap", out_addr_o, 32'h0);
        check("d39_empty", 32'(out_valid_o), 32'd0);

        // Reset while half of a straddling instruction is buffered
        step(1, 32'h302, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0113_0000, 0, 0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("r33_valid", 32'(out_valid_o), 32'd0);
        check("r33_addr", out_addr_o, BOOT_ADDR);
        q.delete();
        m_pc = BOOT_ADDR;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(0, 0, 0, 0, 0, 1);

        // Randomized traffic checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            bit          rd, iv, ie, ordy;
            logic [31:0] ra;
            rd   = ($urandom_range(99) < 3);
            ra   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
            iv   = ($urandom_range(99) < 70);
            ie   = ($urandom_range(99) < 5);
            ordy = ($urandom_range(99) < 70);
            step(rd, ra, iv, $urandom, ie, ordy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_instr_aligner.md
IBEX_INSTR_ALIGNER -- requirements
Module: ibex_instr_aligner

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of 32-bit fetch-word entries (legal range 2..8).
REQ-002 SHALL have parameter BOOT_ADDR, default 32'h0000_0080, PC loaded at reset.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port redirect_i  input  1  flush plus PC reload (branch/jump/exception).
REQ-006 SHALL have port redirect_addr_i  input  32  new PC; bit 0 ignored.
REQ-007 SHALL have port in_valid_i  input  1  fetch word present.
REQ-008 SHALL have port in_rdata_i  input  32  word-aligned fetch data.
REQ-009 SHALL have port in_err_i  input  1  bus error for this word.
REQ-010 SHALL have port in_ready_o  output  1  word accepted when in_valid_i && in_ready_o.
REQ-011 SHALL have port out_valid_o  output  1  complete instruction available.
REQ-012 SHALL have port out_ready_i  input  1  decoder consumes instruction.
REQ-013 SHALL have port out_rdata_o  output  32  aligned instruction to compressed decoder.
REQ-014 SHALL have port out_addr_o  output  32  PC of out_rdata_o.
REQ-015 SHALL have port out_err_o  output  1  fetch error on any contributing word.

Function
REQ-016 SHALL hold fetch words in a DEPTH-entry circular FIFO (head/tail pointers, count 0..DEPTH) plus a halfword PC register pc.
REQ-017 SHALL drive in_ready_o = (count < DEPTH), from registered count only; a same-cycle pop does not raise it.
REQ-018 SHALL allow push and pop of a word in the same cycle; count unchanged.
REQ-019 pc[1]=0: instr = head[31:0]; compressed iff head[1:0]!=2'b11; out_valid_o = (count>=1).
REQ-020 pc[1]=1, head[17:16]!=2'b11: compressed instr = head[31:16]; out_valid_o = (count>=1).
REQ-021 pc[1]=1, head[17:16]==2'b11: straddling instr = {head+1[15:0], head[31:16]}; out_valid_o = (count>=2).
REQ-022 SHALL drive out_rdata_o[31:16]=16'h0 for compressed instructions.
REQ-023 SHALL set out_err_o if head err set, or head+1 err set for a straddling instruction; out_valid_o asserts with count>=1 if head err set, regardless of REQ-021.
REQ-024 SHALL drive out_addr_o = {pc[31:1],1'b0}.
REQ-025 On out handshake: pc += 2 (compressed) or 4 (32-bit), wrapping mod 2^32.
REQ-026 On out handshake SHALL pop 1 word when the new pc crosses into the next word, 2 words never (straddle pops head only; head+1 becomes head with pc[1]=1).
REQ-027 out_valid_o, out_rdata_o, out_err_o SHALL be combinational from registered state only (no path from in_* or out_ready_i).
REQ-028 On redirect_i: count:=0, pointers:=0, pc:={redirect_addr_i[31:1],1'b0} next cycle; same-cycle push and pop discarded; out_valid_o=0 that cycle.
REQ-029 After redirect with pc[1]=1, lower half of first fetched word SHALL be skipped.
REQ-030 SHALL ignore out_ready_i when out_valid_o=0 and in_valid_i when in_ready_o=0.

Reset
REQ-031 On rst_ni low, asynchronously: count=0, pointers=0, pc=BOOT_ADDR.
REQ-032 During/after reset until first push: in_ready_o=1, out_valid_o=0, out_err_o=0, out_addr_o=BOOT_ADDR.
REQ-033 Reset asserted mid-straddle SHALL discard buffered halfword; no stale output after release.

Verification
REQ-034 Reset, push 32'h0041_0113 -> out_valid_o=1, out_rdata_o=32'h0041_0113, out_addr_o=32'h80; after pop out_addr_o=32'h84, count=0.
REQ-035 Push 32'h4505_4501, out_ready_i=1 -> 32'h0000_4501 @0x80 then 32'h0000_4505 @0x82; one word popped after second.
REQ-036 Redirect to 32'h102, push 32'h0113_0001 then 32'hXXXX_0041 -> out_valid_o=0 after first word, then 32'h0041_0113 @0x102.
REQ-037 Fill DEPTH=3 with out_ready_i=0 -> in_ready_o=0 at count=3; one pop plus in_valid_i same cycle -> push rejected, in_ready_o=1 next cycle.
REQ-038 Straddle with head+1 in_err_i=1 -> out_err_o=1, out_addr_o of first halfword.
REQ-039 Redirect to 32'hFFFF_FFFE, push compressed word -> out_addr_o=32'hFFFF_FFFE, next pc 32'h0000_0000.
